fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Sequences the instruction memory for the pipelined MIPS core: owns the PC, drives the instruction-memory address, and loads the IF/ID pipeline register.
- Honours hazard-unit stalls and branch/jump redirects from ID.
- Stops fetching cleanly when the PC runs past the end of the program ROM.
- Sits between the instruction memory and the decode stage.

Parameters:
- MEM_WORDS, 15, number of 32-bit words in the instruction ROM; fetch limit LIMIT = MEM_WORDS*4 bytes.
- PC_RESET, 32'd0, PC value loaded on reset.
- CNT_W, 16, width of the fetch counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; leaves IDLE and begins fetching.
- stall  in  1  hazard-unit hold: freezes PC and IF/ID.
- redirect  in  1  branch/jump taken in ID.
- redirect_target  in  32  byte address of the new PC.
- imem_addr  out  32  address to instruction memory; combinational, equals pc.
- imem_instr  in  32  instruction word returned by memory in the same cycle.
- if_id_instr  out  32  registered instruction to decode.
- if_id_pc4  out  32  registered PC+4 of that instruction.
- if_id_valid  out  1  IF/ID holds a real instruction.
- halted  out  1  high while in HALT.
- fetch_count  out  CNT_W  number of instructions delivered; saturating.

Behaviour:
- Reset (synchronous, high on a rising edge) puts the block in this state:
  - pc = PC_RESET; state = IDLE.
  - if_id_instr = 0 (NOP), if_id_pc4 = 0, if_id_valid = 0.
  - halted = 0, fetch_count = 0.
- Reset overrides every other input, including reset asserted mid-fetch or during HALT.
- Memory access: imem_addr = pc, no registering; imem_instr is sampled on the same edge. Fetch-to-IF/ID latency is 1 cycle.
- redirect_target[1:0] is forced to 00 before loading into pc.
- States: IDLE, RUN, HALT.
- IDLE:
  - pc holds; IF/ID stays NOP with valid = 0.
  - stall and redirect are ignored.
  - start = 1: go to RUN. The first fetch happens in the next cycle.
- RUN, one priority per edge:
  1. redirect = 1 (wins even when stall = 1):
     - pc <= aligned target.
     - IF/ID <= NOP, valid = 0 (flushes the wrong-path instruction).
     - Not counted.
  2. stall = 1: pc, if_id_instr, if_id_pc4 and if_id_valid all hold.
  3. pc >= LIMIT:
     - go to HALT; halted <= 1.
     - IF/ID <= NOP, valid = 0; pc holds.
  4. Otherwise:
     - if_id_instr <= imem_instr; if_id_pc4 <= pc + 4; if_id_valid <= 1.
     - pc <= pc + 4.
     - fetch_count increments.
- HALT:
  - IF/ID held at NOP, valid = 0; stall and start are ignored.
  - redirect with aligned target < LIMIT: pc <= target, halted <= 0, go to RUN.
  - redirect with target >= LIMIT is ignored.
- Arithmetic: pc + 4 is 32-bit and wraps modulo 2^32. The LIMIT compare is unsigned on the full 32 bits.
- fetch_count saturates at 2^CNT_W - 1 and never wraps.
- A redirect that targets >= LIMIT in RUN is accepted. HALT is then entered on the following edge by rule 3.

Decomposition:
- Shared package (mips_pkg):
  - state encoding localparams: ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_HALT = 2'd2.
  - NOP_INSTR = 32'd0.
  - word size constant 4.
- One natural sub-module, if_id_reg: a 65-bit register (instr, pc4, valid) with load, hold and flush controls; fetch_sequencer drives those controls.
- The FSM, PC and counter stay in the top module.

Test Plan:
- Reset, then start, with mock memory word 0 = 32'h20110001 and word 1 = 32'h20120002:
  - imem_addr reads 0 then 4.
  - if_id_instr = 20110001 with pc4 = 4, then 20120002 with pc4 = 8.
  - valid = 1; fetch_count = 2.
- stall high for 3 cycles at pc = 8:
  - imem_addr stays 8.
  - if_id_instr/pc4 unchanged; fetch_count unchanged.
  - Fetching resumes at 8 after stall drops.
- redirect = 1, target 32'h1E, with stall also high:
  - Next cycle pc = 0x1C, if_id_valid = 0, if_id_instr = 0.
  - The following fetch has pc4 = 0x20.
- Run from 0 without stalls:
  - After 15 fetches, pc = 60 and the next edge asserts halted.
  - valid = 0; fetch_count = 15; imem_addr stays 60.
- In HALT:
  - redirect to 0x40 is ignored (halted stays 1).
  - redirect to 0x08 → halted = 0, RUN, next if_id_pc4 = 0x0C.
- Reset asserted mid-RUN at pc = 0x24: the next edge shows pc = 0, IDLE, all outputs at reset values, and start is required to resume.

Source files
------------

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared constants for the MIPS fetch front end: FSM state
//                encoding, the NOP instruction word and the word size in
//                bytes.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    // Fetch sequencer state encoding
    localparam logic [1:0]  ST_IDLE    = 2'd0;
    localparam logic [1:0]  ST_RUN     = 2'd1;
    localparam logic [1:0]  ST_HALT    = 2'd2;

    // All-zero word decodes as sll $0,$0,0
    localparam logic [31:0] NOP_INSTR  = 32'd0;

    // Bytes per instruction word
    localparam logic [31:0] WORD_BYTES = 32'd4;

endpackage
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_reg
//  Description : IF/ID pipeline register (instruction, PC+4, valid).
//                flush has priority over load; with neither asserted the
//                register holds its contents.
//  Ports       : clk, reset      - clock, synchronous active-high reset
//                load            - capture instr_d / pc4_d, mark valid
//                flush           - replace contents with NOP, valid = 0
//                instr_d, pc4_d  - incoming instruction and its PC+4
//                instr, pc4      - registered instruction and PC+4
//                valid           - register holds a real instruction
//  Revision    : 1.0 - initial release
// ============================================================================
module if_id_reg
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        flush,
    input  logic [31:0] instr_d,
    input  logic [31:0] pc4_d,
    output logic [31:0] instr,
    output logic [31:0] pc4,
    output logic        valid
);

    logic [31:0] r_instr;
    logic [31:0] r_pc4;
    logic        r_valid;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_instr <= NOP_INSTR;
            r_pc4   <= 32'd0;
            r_valid <= 1'b0;
        end else if (load) begin
            r_instr <= instr_d;
            r_pc4   <= pc4_d;
            r_valid <= 1'b1;
        end
    end

    assign instr = r_instr;
    assign pc4   = r_pc4;
    assign valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_sequencer
//  Description : Instruction fetch stage of the pipelined MIPS core. Owns the
//                PC, addresses the instruction ROM combinationally, loads the
//                IF/ID register, honours stalls and ID-stage redirects, and
//                halts once the PC runs past the end of the ROM.
//  Ports       : clk, reset             - clock, synchronous active-high reset
//                start                  - leave IDLE and begin fetching
//                stall                  - hazard hold of PC and IF/ID
//                redirect, redirect_target - taken branch/jump from ID
//                imem_addr, imem_instr  - instruction ROM interface
//                if_id_instr, if_id_pc4, if_id_valid - IF/ID register
//                halted                 - high while in HALT
//                fetch_count            - saturating delivered-instruction count
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer
    import mips_pkg::*;
#(
    parameter int          MEM_WORDS = 15,
    parameter logic [31:0] PC_RESET  = 32'd0,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stall,
    input  logic             redirect,
    input  logic [31:0]      redirect_target,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_instr,
    output logic [31:0]      if_id_instr,
    output logic [31:0]      if_id_pc4,
    output logic             if_id_valid,
    output logic             halted,
    output logic [CNT_W-1:0] fetch_count
);

    localparam logic [31:0]      c_LIMIT   = 32'(MEM_WORDS) * WORD_BYTES;
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic [1:0]       r_state;
    logic [31:0]      r_pc;
    logic             r_halted;
    logic [CNT_W-1:0] r_fetch_count;

    logic [31:0]      w_target;
    logic [31:0]      w_pc_plus4;
    logic             w_at_limit;
    logic             w_load;
    logic             w_flush;

    // Branch targets are word aligned; the low two bits are dropped.
    assign w_target   = redirect_target & ~32'd3;
    assign w_pc_plus4 = r_pc + WORD_BYTES;
    assign w_at_limit = (r_pc >= c_LIMIT);

    // IF/ID control. Outside RUN the register is kept flushed so decode
    // always sees a NOP with valid low.
    always_comb begin
        w_load  = 1'b0;
        w_flush = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (redirect)        w_flush = 1'b1;
                else if (stall)      w_flush = 1'b0;
                else if (w_at_limit) w_flush = 1'b1;
                else                 w_load  = 1'b1;
            end
            default: w_flush = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_pc          <= PC_RESET;
            r_halted      <= 1'b0;
            r_fetch_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (redirect) begin
                        // A target past the ROM is accepted here; the
                        // limit check halts on the following edge.
                        r_pc <= w_target;
                    end else if (stall) begin
                        r_pc <= r_pc;
                    end else if (w_at_limit) begin
                        r_state  <= ST_HALT;
                        r_halted <= 1'b1;
                    end else begin
                        r_pc <= w_pc_plus4;
                        if (r_fetch_count != c_CNT_MAX)
                            r_fetch_count <= r_fetch_count + 1'b1;
                    end
                end
                ST_HALT: begin
                    // Only an in-range redirect restarts fetching.
                    if (redirect && (w_target < c_LIMIT)) begin
                        r_pc     <= w_target;
                        r_halted <= 1'b0;
                        r_state  <= ST_RUN;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    if_id_reg u_if_id_reg (
        .clk     (clk),
        .reset   (reset),
        .load    (w_load),
        .flush   (w_flush),
        .instr_d (imem_instr),
        .pc4_d   (w_pc_plus4),
        .instr   (if_id_instr),
        .pc4     (if_id_pc4),
        .valid   (if_id_valid)
    );

    assign imem_addr   = r_pc;
    assign halted      = r_halted;
    assign fetch_count = r_fetch_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_sequencer
//  Description : Self-checking bench for fetch_sequencer. Directed vector
//                table for the documented scenarios, then randomized traffic
//                against a behavioural reference model. A second instance
//                with a 3-bit counter shares all stimulus to exercise
//                counter saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

    localparam int          MEM_WORDS = 15;
    localparam logic [31:0] LIMIT     = 32'd60;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_target = 32'd0;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic        halted;
    logic [15:0] fetch_count;

    logic [31:0] imem_addr_s;
    logic [31:0] if_id_instr_s;
    logic [31:0] if_id_pc4_s;
    logic        if_id_valid_s;
    logic        halted_s;
    logic [2:0]  fetch_count_s;

    logic [31:0] rom [0:MEM_WORDS-1];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fetch_sequencer #(.MEM_WORDS(MEM_WORDS), .PC_RESET(32'd0), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall),
        .redirect(redirect), .redirect_target(redirect_target),
        .imem_addr(imem_addr), .imem_instr(imem_instr),
        .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4),
        .if_id_valid(if_id_valid), .halted(halted), .fetch_count(fetch_count)
    );

    // Same stimulus, narrow counter; its PC tracks the main instance exactly.
    fetch_sequencer #(.MEM_WORDS(MEM_WORDS), .PC_RESET(32'd0), .CNT_W(3)) dut_sat (
        .clk(clk), .reset(reset), .start(start), .stall(stall),
        .redirect(redirect), .redirect_target(redirect_target),
        .imem_addr(imem_addr_s), .imem_instr(imem_instr),
        .if_id_instr(if_id_instr_s), .if_id_pc4(if_id_pc4_s),
        .if_id_valid(if_id_valid_s), .halted(halted_s), .fetch_count(fetch_count_s)
    );

    // Mock ROM: out-of-range reads return a poison word.
    always_comb begin
        if (imem_addr < LIMIT) imem_instr = rom[imem_addr[5:2]];
        else                   imem_instr = 32'hFFFF_FFFF;
    end

    function automatic logic [31:0] rom_word(int k);
        if (k == 0)      return 32'h2011_0001;
        else if (k == 1) return 32'h2012_0002;
        else             return 32'h1000_0000 + 32'(k);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic check_all(logic [31:0] pc, logic [31:0] instr, logic [31:0] pc4,
                             logic valid, logic hlt, int cnt);
        int sat;
        sat = (cnt > 7) ? 7 : cnt;
        check("imem_addr",   imem_addr,   pc);
        check("if_id_instr", if_id_instr, instr);
        check("if_id_pc4",   if_id_pc4,   pc4);
        check("if_id_valid", {31'd0, if_id_valid}, {31'd0, valid});
        check("halted",      {31'd0, halted},      {31'd0, hlt});
        check("fetch_count", {16'd0, fetch_count}, 32'(cnt));
        check("sat_count",   {29'd0, fetch_count_s}, 32'(sat));
    endtask

    // ------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic        rst, st, stl, rd;
        logic [31:0] tgt;
        logic [31:0] pc, instr, pc4;
        logic        valid, hlt;
        int          cnt;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] f_pc;
    int          f_cnt;

    task automatic add(logic rst, logic st, logic stl, logic rd, logic [31:0] tgt,
                       logic [31:0] pc, logic [31:0] instr, logic [31:0] pc4,
                       logic valid, logic hlt, int cnt);
        vec_t v;
        v.rst = rst; v.st = st; v.stl = stl; v.rd = rd; v.tgt = tgt;
        v.pc = pc; v.instr = instr; v.pc4 = pc4;
        v.valid = valid; v.hlt = hlt; v.cnt = cnt;
        vecs.push_back(v);
    endtask

    // n plain fetch cycles starting from f_pc
    task automatic add_fetch(int n);
        for (int i = 0; i < n; i++) begin
            f_cnt++;
            add(0, 0, 0, 0, 0, f_pc + 4, rom_word(int'(f_pc >> 2)), f_pc + 4, 1, 0, f_cnt);
            f_pc = f_pc + 4;
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model state
    // ------------------------------------------------------------------
    typedef enum int { M_IDLE, M_RUN, M_HALT } mode_t;
    mode_t       m_mode;
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid, m_halted;
    int          m_cnt;

    task automatic model_step(logic rst, logic st, logic stl, logic rd, logic [31:0] tgt);
        logic [31:0] t;
        t = {tgt[31:2], 2'b00};
        if (rst) begin
            m_mode = M_IDLE; m_pc = 0; m_instr = 0; m_pc4 = 0;
            m_valid = 0; m_halted = 0; m_cnt = 0;
        end else if (m_mode == M_IDLE) begin
            if (st) m_mode = M_RUN;
        end else if (m_mode == M_RUN) begin
            if (rd) begin
                m_pc = t; m_instr = 0; m_pc4 = 0; m_valid = 0;
            end else if (stl) begin
                // everything holds
            end else if (m_pc >= LIMIT) begin
                m_mode = M_HALT; m_halted = 1; m_instr = 0; m_pc4 = 0; m_valid = 0;
            end else begin
                m_instr = rom[m_pc / 4];
                m_pc4   = m_pc + 4;
                m_valid = 1;
                m_pc    = m_pc + 4;
                if (m_cnt < 65535) m_cnt++;
            end
        end else begin
            if (rd && t < LIMIT) begin
                m_pc = t; m_halted = 0; m_mode = M_RUN;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) rom[i] = rom_word(i);

        // Basic fetch from reset
        f_pc = 0; f_cnt = 0;
        add(1, 0, 0, 0, 0,       0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0,       0, 0, 0, 0, 0, 0);
        add_fetch(2);
        // Stall at pc = 8 for three cycles, then resume
        for (int i = 0; i < 3; i++)
            add(0, 0, 1, 0, 0,   8, rom_word(1), 8, 1, 0, 2);
        add_fetch(1);
        // Redirect wins over stall, unaligned target aligned down
        add(0, 0, 1, 1, 32'h1E,  32'h1C, 0, 0, 0, 0, 3);
        f_pc = 32'h1C;
        add_fetch(1);
        // Full run from 0 to the ROM end
        add(1, 0, 0, 0, 0,       0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0,       0, 0, 0, 0, 0, 0);
        f_pc = 0; f_cnt = 0;
        add_fetch(15);
        add(0, 0, 0, 0, 0,       60, 0, 0, 0, 1, 15);
        // HALT ignores start/stall and out-of-range redirects
        add(0, 1, 1, 0, 0,       60, 0, 0, 0, 1, 15);
        add(0, 0, 0, 1, 32'h40,  60, 0, 0, 0, 1, 15);
        add(0, 0, 0, 1, 32'h3C,  60, 0, 0, 0, 1, 15);
        add(0, 0, 0, 1, 32'h08,  8, 0, 0, 0, 0, 15);
        f_pc = 8; f_cnt = 15;
        add_fetch(7);
        // Reset mid-RUN at pc = 0x24 overrides everything
        add(1, 1, 1, 1, 32'h10,  0, 0, 0, 0, 0, 0);
        add(0, 0, 1, 1, 32'h10,  0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0,       0, 0, 0, 0, 0, 0);
        f_pc = 0; f_cnt = 0;
        add_fetch(1);
        // Out-of-range redirect in RUN accepted; stall outranks limit check
        add(0, 0, 0, 1, 32'h100, 32'h100, 0, 0, 0, 0, 1);
        add(0, 0, 1, 0, 0,       32'h100, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0,       32'h100, 0, 0, 0, 1, 1);
        // Reset during HALT
        add(1, 0, 0, 0, 0,       0, 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            reset           = vecs[i].rst;
            start           = vecs[i].st;
            stall           = vecs[i].stl;
            redirect        = vecs[i].rd;
            redirect_target = vecs[i].tgt;
            @(posedge clk);
            #1;
            check_all(vecs[i].pc, vecs[i].instr, vecs[i].pc4,
                      vecs[i].valid, vecs[i].hlt, vecs[i].cnt);
        end

        // ------------------------------------------------------------------
        // Randomized traffic against the reference model
        // ------------------------------------------------------------------
        for (int i = 0; i < MEM_WORDS; i++) rom[i] = $urandom;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            reset    = (cyc == 0) || ($urandom_range(0, 199) == 0);
            start    = ($urandom_range(0, 9) == 0);
            stall    = ($urandom_range(0, 4) == 0);
            redirect = ($urandom_range(0, 11) == 0);
            case ($urandom_range(0, 3))
                0:       redirect_target = 32'($urandom_range(0, 70));
                1:       redirect_target = 32'($urandom_range(0, 14)) * 4;
                2:       redirect_target = $urandom;
                default: redirect_target = 32'd60 + 32'($urandom_range(0, 3)) * 4;
            endcase
            model_step(reset, start, stall, redirect, redirect_target);
            @(posedge clk);
            #1;
            check_all(m_pc, m_instr, m_pc4, m_valid, m_halted, m_cnt);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
